// File: rtl/mmio_ctrl.sv
// Purpose: MMIO controller for the 0x8xxx_xxxx region: UART status/RX/TX registers, 4-entry TX FIFO, cycle/instret counters.
// Latency: loads return on io_dout one cycle after re is sampled; a pushed TX byte is visible on tx_data the cycle after the push.
// Backpressure: TX FIFO holds bytes while tx_ready=0; pushes into a full FIFO are dropped unless a pop happens that same cycle.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   addr, wdata, we, re     CPU load/store access (only acted on inside IO_REGION)
//   inst_retire             one instruction retired this cycle
//   rx_data/rx_valid/rx_ready  UART receiver hand-off (rx_ready is a one-cycle pop pulse)
//   tx_data/tx_valid/tx_ready  UART transmitter hand-off from the TX FIFO head
//   io_dout                 registered load data
module mmio_ctrl #(
    parameter logic [3:0] IO_REGION = 4'b1000,
    parameter int         TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] io_dout
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] OFF_UART_CTRL = 8'h00;
    localparam logic [7:0] OFF_UART_RX   = 8'h04;
    localparam logic [7:0] OFF_UART_TX   = 8'h08;
    localparam logic [7:0] OFF_CYC_CNT   = 8'h10;
    localparam logic [7:0] OFF_INST_CNT  = 8'h14;
    localparam logic [7:0] OFF_CNT_RST   = 8'h18;

    // Address qualification
    logic       in_region;
    logic       wr_sel;
    logic       rd_sel;
    logic [7:0] offset;

    assign in_region = (addr[31:28] == IO_REGION);
    assign wr_sel    = we && in_region;
    assign rd_sel    = re && in_region;
    assign offset    = addr[7:0];

    // Only the low byte of the offset and of store data is meaningful here.
    logic unused_bits;
    assign unused_bits = ^{addr[27:8], wdata[31:8]};

    // TX FIFO
    logic [7:0]    tx_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_pop;

    assign tx_full     = (tx_count == CW'(TX_DEPTH));
    assign tx_valid    = (tx_count != '0);
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = wr_sel && (offset == OFF_UART_TX);
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts it.
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    // Storage is not reset, so the head is masked to keep tx_data at 0 while empty.
    assign tx_data     = tx_valid ? tx_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            // Pointers wrap naturally because TX_DEPTH is a power of two.
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // RX pop: combinational so the receiver advances on the same edge the byte is captured.
    assign rx_ready = rd_sel && (offset == OFF_UART_RX) && rx_valid;

    // Performance counters
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
    logic        cnt_clr;

    assign cnt_clr = wr_sel && (offset == OFF_CNT_RST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 32'd1;
            inst_cnt <= inst_cnt + 32'(inst_retire);
        end
    end

    // Load data select; all sources are pre-edge state.
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'h0;
        unique case (offset)
            OFF_UART_CTRL: rd_val = {30'h0, rx_valid, !tx_full};
            OFF_UART_RX:   rd_val = {24'h0, rx_data};
            OFF_CYC_CNT:   rd_val = cyc_cnt;
            OFF_INST_CNT:  rd_val = inst_cnt;
            default:       rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_dout <= '0;
        end else if (rd_sel) begin
            io_dout <= rd_val;
        end
    end

endmodule
